range_tracker: RTL

//  Parametrised streaming range tracker. Between go and finish it tracks min,
//  max and sample count of a qualified data stream. On finish it publishes

---
 rtl/range_tracker_if.sv | 30 +++
 rtl/range_tracker.sv | 126 ++++++++++++
 2 files changed

// File: rtl/range_tracker_if.sv
// Stream and result signals of range_tracker, bundled for connection.
// master drives samples and controls; slave is the tracker itself.
interface range_tracker_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [WIDTH-1:0]           data_in;
    logic                       data_valid;
    logic                       go;
    logic                       finish;
    logic [WIDTH-1:0]           min_val;
    logic [WIDTH-1:0]           max_val;
    logic [WIDTH-1:0]           range;
    logic [CNT_WIDTH-1:0]       count;
    logic                       count_sat;
    logic                       busy;
    logic                       done;
    logic                       debug_error;
    logic [WIDTH+CNT_WIDTH-1:0] sum;

    modport master (
        output data_in, data_valid, go, finish,
        input  min_val, max_val, range, count, count_sat, busy, done, debug_error, sum
    );

    modport slave (
        input  data_in, data_valid, go, finish,
        output min_val, max_val, range, count, count_sat, busy, done, debug_error, sum
    );
endinterface

// File: rtl/range_tracker.sv
// Streaming min/max/count tracker publishing range = max - min with a done pulse.
// Optional running-sum accumulator is built when RANGE_TRACKER_SUM_EN is defined.
module range_tracker #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 8,
    parameter bit          SIGNED    = 1'b0
) (
    input logic             clock,
    input logic             reset,
    range_tracker_if.slave  bus
);
    localparam int unsigned SumW = WIDTH + CNT_WIDTH;

    typedef enum logic [1:0] {StIdle, StActive, StError} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     min_q, min_d;
    logic [WIDTH-1:0]     max_q, max_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 done_q, done_d;
    logic                 load, upd;

    function automatic logic lt(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        if (SIGNED) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        upd     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.finish) begin
                    state_d = StError;
                end else if (bus.go) begin
                    state_d = StActive;
                    load    = 1'b1;
                end
            end
            StActive: begin
                // finish wins over go; the sample on the finish cycle still counts
                if (bus.finish) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    upd     = bus.data_valid;
                end else if (bus.go) begin
                    load = 1'b1;
                end else begin
                    upd = bus.data_valid;
                end
            end
            StError: begin
                if (bus.go) begin
                    state_d = StActive;
                    load    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        if (load) begin
            min_d   = bus.data_in;
            max_d   = bus.data_in;
            count_d = CNT_WIDTH'(1);
        end else if (upd) begin
            if (lt(bus.data_in, min_q)) min_d = bus.data_in;
            if (lt(max_q, bus.data_in)) max_d = bus.data_in;
            if (count_q != '1) count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef RANGE_TRACKER_SUM_EN
    logic [SumW-1:0] sum_q, sum_d;
    logic [SumW-1:0] data_ext;

    assign data_ext = SIGNED ? {{CNT_WIDTH{bus.data_in[WIDTH-1]}}, bus.data_in}
                             : {{CNT_WIDTH{1'b0}}, bus.data_in};

    always_comb begin
        sum_d = sum_q;
        if (load)     sum_d = data_ext;
        else if (upd) sum_d = sum_q + data_ext;
    end

    always_ff @(posedge clock) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign bus.sum = sum_q;
`else
    assign bus.sum = {SumW{1'b0}};
`endif

    assign bus.min_val     = min_q;
    assign bus.max_val     = max_q;
    assign bus.range       = max_q - min_q;
    assign bus.count       = count_q;
    assign bus.count_sat   = (count_q == '1);
    assign bus.busy        = (state_q == StActive);
    assign bus.done        = done_q;
    assign bus.debug_error = (state_q == StError);
endmodule
